// File: rtl/derandomizer_pkg.sv
// derand_pkg: shared constants, state type and Gold-sequence helpers for
// the derandomizer.
//   X_INIT / Y_INIT : LFSR seed values loaded at every start of frame
//   state_e         : framing state (IDLE, RUN)
//   x_next / y_next : one LFSR step of the x and y registers
//   gold_elem       : 2-bit sequence element derived from the current x/y
package derand_pkg;

   localparam logic [17:0] X_INIT = 18'h00001;
   localparam logic [17:0] Y_INIT = 18'h3FFFF;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic [17:0] x_next(input logic [17:0] x);
      return {x[7] ^ x[0], x[17:1]};
   endfunction

   function automatic logic [17:0] y_next(input logic [17:0] y);
      return {y[10] ^ y[7] ^ y[5] ^ y[0], y[17:1]};
   endfunction

   function automatic logic [1:0] gold_elem(input logic [17:0] x,
                                            input logic [17:0] y);
      logic b0;
      logic b1;
      b0 = x[0] ^ y[0];
      b1 = (x[4] ^ x[6] ^ x[15]) ^
           (y[5] ^ y[6] ^ y[8] ^ y[9] ^ y[10] ^ y[11] ^ y[12] ^ y[13] ^
            y[14] ^ y[15]);
      return {b1, b0};
   endfunction

endpackage

// File: rtl/derandomizer_gold_seq_gen.sv
// gold_seq_gen: holds the x/y LFSR pair of the Gold sequence generator.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset, x/y back to their seeds
//   i_load  : restart the sequence from the seeds this cycle
//   i_step  : advance the LFSRs by one element
//   o_seq   : current 2-bit element (combinational)
module gold_seq_gen
   import derand_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_load,
   input  logic       i_step,
   output logic [1:0] o_seq
);

   logic [17:0] x_q;
   logic [17:0] y_q;
   logic [17:0] x_d;
   logic [17:0] y_d;
   logic [17:0] x_cur;
   logic [17:0] y_cur;

   // A load presents element 0 in the same cycle, so a start-of-frame symbol
   // is descrambled with the seed state and the step lands on element 1.
   always_comb begin
      x_cur = i_load ? X_INIT : x_q;
      y_cur = i_load ? Y_INIT : y_q;
      x_d   = i_step ? x_next(x_cur) : x_cur;
      y_d   = i_step ? y_next(y_cur) : y_cur;
   end

   assign o_seq = gold_elem(x_cur, y_cur);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         x_q <= X_INIT;
         y_q <= Y_INIT;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/derandomizer.sv
// derandomizer: strips the CCSDS Gold-sequence randomization from a framed
// stream of 2-bit symbols, one output register stage with backpressure.
//   FRAME_SYMS  : symbols per frame (2..65535)
//   i_clk       : clock, rising edge
//   i_reset     : synchronous active-high reset
//   i_data      : randomized symbol in
//   i_valid     : i_data valid
//   i_sof       : first symbol of a frame (qualified by i_valid)
//   o_ready     : input symbol accepted when i_valid && o_ready
//   o_data      : derandomized symbol out
//   o_valid     : o_data valid
//   o_last      : o_data closes the frame
//   i_ready     : downstream accepts when o_valid && i_ready
//   o_sync_err  : one-cycle pulse on a framing error
//   o_frame_cnt : completed frames delivered downstream, only when the
//                 macro DERAND_FRAME_CNT_EN is defined
module derandomizer
   import derand_pkg::*;
#(
   parameter int FRAME_SYMS = 4096
)(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [1:0]  i_data,
   input  logic        i_valid,
   input  logic        i_sof,
   output logic        o_ready,
   output logic [1:0]  o_data,
   output logic        o_valid,
   output logic        o_last,
   input  logic        i_ready,
   output logic        o_sync_err
`ifdef DERAND_FRAME_CNT_EN
   ,
   output logic [15:0] o_frame_cnt
`endif
);

   localparam logic [15:0] LAST_K = 16'(FRAME_SYMS - 1);

   state_e      state_q;
   logic [15:0] cnt_q;
   logic [1:0]  data_q;
   logic        valid_q;
   logic        last_q;
   logic        err_q;

   logic        accept;
   logic        load;
   logic        step;
   logic [1:0]  seq;

   // Output slot is free when empty or being drained this cycle.
   assign o_ready = !valid_q || i_ready;
   assign accept  = i_valid && o_ready;
   assign load    = accept && i_sof;
   // A stray symbol in IDLE is dropped, so the sequence must not advance.
   assign step    = accept && (i_sof || (state_q == RUN));

   gold_seq_gen u_gold (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_load  (load),
      .i_step  (step),
      .o_seq   (seq)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (valid_q && i_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
         end
         if (accept) begin
            case (state_q)
               IDLE: begin
                  if (i_sof) begin
                     valid_q <= 1'b1;
                     data_q  <= i_data ^ seq;
                     last_q  <= 1'b0;
                     cnt_q   <= 16'd1;
                     state_q <= RUN;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               RUN: begin
                  valid_q <= 1'b1;
                  data_q  <= i_data ^ seq;
                  if (i_sof) begin
                     err_q  <= 1'b1;
                     last_q <= 1'b0;
                     cnt_q  <= 16'd1;
                  end else if (cnt_q == LAST_K) begin
                     last_q  <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end else begin
                     last_q <= 1'b0;
                     cnt_q  <= cnt_q + 16'd1;
                  end
               end
            endcase
         end
      end
   end

   assign o_data     = data_q;
   assign o_valid    = valid_q;
   assign o_last     = last_q;
   assign o_sync_err = err_q;

`ifdef DERAND_FRAME_CNT_EN
   logic [15:0] fcnt_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         fcnt_q <= '0;
      end else if (valid_q && last_q && i_ready) begin
         fcnt_q <= fcnt_q + 16'd1;
      end
   end

   assign o_frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_derandomizer.sv
module tb_derandomizer;

   localparam int FS = 16;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic [1:0] i_data = 2'b00;
   logic       i_valid = 1'b0;
   logic       i_sof = 1'b0;
   logic       i_ready = 1'b0;
   logic       o_ready;
   logic [1:0] o_data;
   logic       o_valid;
   logic       o_last;
   logic       o_sync_err;
`ifdef DERAND_FRAME_CNT_EN
   logic [15:0] o_frame_cnt;
   logic [15:0] exp_fcnt = '0;
`endif

   always #5 clk = ~clk;

   derandomizer #(.FRAME_SYMS(FS)) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .i_sof      (i_sof),
      .o_ready    (o_ready),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_last     (o_last),
      .i_ready    (i_ready),
      .o_sync_err (o_sync_err)
`ifdef DERAND_FRAME_CNT_EN
      ,
      .o_frame_cnt(o_frame_cnt)
`endif
   );

   int n_vec = 0;
   int n_err = 0;
   int ready_pct = 100;

   // Reference model: precomputed Gold elements, framing position, queues.
   logic [1:0] el [0:FS-1];
   logic       m_run = 1'b0;
   int         m_k = 0;
   logic [2:0] exp_q [$];      // {last, data}
   logic       err_hist [$];   // expected sync_err, one entry per cycle

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic build_seq();
      logic [17:0] x;
      logic [17:0] y;
      logic [17:0] xs;
      logic [17:0] ys;
      x = 18'h00001;
      y = 18'h3FFFF;
      for (int unsigned k = 0; k < FS; k++) begin
         el[k][0] = x[0] ^ y[0];
         el[k][1] = ^{x[4], x[6], x[15]} ^
                    ^{y[5], y[6], y[15:8]};
         xs = x;
         ys = y;
         x  = {xs[7] ^ xs[0], xs[17:1]};
         y  = {ys[10] ^ ys[7] ^ ys[5] ^ ys[0], ys[17:1]};
      end
   endtask

   // One driver cycle: apply inputs, decide acceptance, update the model.
   task automatic cyc(input logic v, input logic [1:0] d, input logic s,
                      input logic rst, output logic acc);
      logic e;
      logic lst;
      @(negedge clk);
      #1;
      i_reset = rst;
      i_valid = v;
      i_data  = d;
      i_sof   = s;
      i_ready = rst ? 1'b0 : (int'($urandom_range(0, 99)) < ready_pct);
      #1;
      e   = 1'b0;
      acc = !rst && v && o_ready;
      if (rst) begin
         m_run = 1'b0;
         m_k   = 0;
         exp_q.delete();
      end else if (acc) begin
         if (s) begin
            e = m_run;
            exp_q.push_back({1'b0, d ^ el[0]});
            m_k   = 1;
            m_run = 1'b1;
         end else if (!m_run) begin
            e = 1'b1;
         end else begin
            lst = (m_k == FS - 1);
            exp_q.push_back({lst, d ^ el[m_k]});
            m_k++;
            if (lst) m_run = 1'b0;
         end
      end
      err_hist.push_back(e);
   endtask

   task automatic send(input logic [1:0] d, input logic s);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
         cyc(1'b1, d, s, 1'b0, acc);
         n++;
      end
      chk("send_accepted", 16'(acc), 16'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int unsigned i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, acc);
   endtask

   task automatic do_reset(input int n);
      logic acc;
      for (int unsigned i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b1, acc);
   endtask

   // Monitor: peeks the scoreboard head whenever o_valid, pops on handshake.
   initial begin
      logic [2:0] exp;
      logic       e;
      forever begin
         @(negedge clk);
         #3;
         if (err_hist.size() >= 2) begin
            e = err_hist.pop_front();
            chk("sync_err", 16'(o_sync_err), 16'(e));
         end
`ifdef DERAND_FRAME_CNT_EN
         chk("frame_cnt", o_frame_cnt, exp_fcnt);
         if (i_reset) exp_fcnt = '0;
`endif
         if (!i_reset) begin
            if (!o_valid || !i_ready)
               chk("o_ready", 16'(o_ready), 16'(!o_valid));
            if (o_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_output", 16'(o_valid), 16'd0);
               end else begin
                  exp = exp_q[0];
                  chk("o_data", 16'(o_data), 16'(exp[1:0]));
                  chk("o_last", 16'(o_last), 16'(exp[2]));
                  if (i_ready) begin
                     void'(exp_q.pop_front());
`ifdef DERAND_FRAME_CNT_EN
                     if (exp[2]) exp_fcnt = exp_fcnt + 16'd1;
`endif
                  end
               end
            end
         end
      end
   end

   initial begin
      logic       acc;
      logic [1:0] p;
      int         tx_k;
      int         r;
      build_seq();

      // Reset values.
      ready_pct = 100;
      do_reset(2);
      chk("rst_o_valid", 16'(o_valid), 16'd0);
      chk("rst_o_last", 16'(o_last), 16'd0);
      chk("rst_o_data", 16'(o_data), 16'd0);
      chk("rst_o_sync_err", 16'(o_sync_err), 16'd0);
      chk("rst_o_ready", 16'(o_ready), 16'd1);
      do_reset(1);

      // All-zero frame: outputs are the raw sequence (00, 01, 01, ...).
      send(2'b00, 1'b1);
      for (int unsigned k = 1; k < FS; k++) send(2'b00, 1'b0);
      idle(3);

      // Symbols without sof while idle are dropped with an error pulse.
      send(2'b01, 1'b0);
      idle(2);
      send(2'b10, 1'b0);
      idle(3);

      // Matching transmitter with random payload and random backpressure.
      ready_pct = 60;
      tx_k = 0;
      for (int unsigned i = 0; i < 3 * FS; i++) begin
         p = 2'($urandom_range(0, 3));
         send(p ^ el[tx_k], tx_k == 0);
         tx_k = (tx_k + 1) % FS;
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      ready_pct = 100;
      idle(4);

      // Resync at k=5: new frame of FS symbols starts at the sof symbol.
      send(2'($urandom_range(0, 3)), 1'b1);
      for (int unsigned k = 1; k < 5; k++) send(2'($urandom_range(0, 3)), 1'b0);
      send(2'b11, 1'b1);
      for (int unsigned k = 1; k < FS; k++) send(2'($urandom_range(0, 3)), 1'b0);
      send(2'b01, 1'b0);
      idle(3);

      // Downstream stall of three cycles with a symbol waiting upstream.
      ready_pct = 0;
      send(2'b10, 1'b1);
      for (int unsigned i = 0; i < 3; i++) begin
         cyc(1'b1, 2'b01, 1'b0, 1'b0, acc);
         chk("stall_no_accept", 16'(acc), 16'd0);
      end
      ready_pct = 100;
      send(2'b01, 1'b0);

      // Reset at k=7, then a clean frame.
      for (int unsigned k = 2; k < 7; k++) send(2'($urandom_range(0, 3)), 1'b0);
      do_reset(2);
      send(2'b10, 1'b1);
      for (int unsigned k = 1; k < FS; k++) send(2'($urandom_range(0, 3)), 1'b0);
      idle(3);

      // Random traffic: gaps, stray sof, occasional reset.
      for (int unsigned i = 0; i < 400; i++) begin
         ready_pct = int'($urandom_range(30, 100));
         r = int'($urandom_range(0, 199));
         if (r < 40) idle(1);
         else if (r < 50) send(2'($urandom_range(0, 3)), 1'b1);
         else if (r < 52) do_reset(1);
         else send(2'($urandom_range(0, 3)), 1'b0);
      end

      ready_pct = 100;
      idle(6);
      chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/derandomizer.md
DERANDOMIZER -- requirements
Module: derandomizer

Interface
REQ-001 SHALL have parameter FRAME_SYMS, default 4096, meaning number of 2-bit symbols per frame (legal range 2..65535).
REQ-002 SHALL have port i_clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_data  input  2  received randomized symbol.
REQ-005 SHALL have port i_valid  input  1  i_data valid.
REQ-006 SHALL have port i_sof  input  1  first symbol of frame, qualified by i_valid.
REQ-007 SHALL have port o_ready  output  1  symbol accepted when i_valid && o_ready.
REQ-008 SHALL have port o_data  output  2  derandomized symbol.
REQ-009 SHALL have port o_valid  output  1  o_data valid.
REQ-010 SHALL have port o_last  output  1  o_data is the last symbol of a frame.
REQ-011 SHALL have port i_ready  input  1  downstream accepts when o_valid && i_ready.
REQ-012 SHALL have port o_sync_err  output  1  one-cycle pulse on framing error.

Function
REQ-013 SHALL regenerate the CCSDS Gold sequence: x init 18'h00001, y init 18'h3FFFF; step x <= {x7^x0, x[17:1]}, y <= {y10^y7^y5^y0, y[17:1]}.
REQ-014 SHALL define sequence element from current state: bit0 = x0^y0; bit1 = (x4^x6^x15)^(y5^y6^y8^y9^y10^y11^y12^y13^y14^y15).
REQ-015 SHALL output o_data = i_data XOR element k for the k-th accepted symbol of a frame, k=0 for the i_sof symbol; LFSRs step once per accepted symbol.
REQ-016 SHALL register output with latency one cycle from acceptance; single output stage, o_ready = !o_valid || i_ready (no combinational path i_valid->o_ready).
REQ-017 SHALL hold o_data/o_valid/o_last stable while o_valid && !i_ready.
REQ-018 SHALL implement states IDLE and RUN; reset enters IDLE.
REQ-019 IDLE: accepted symbol with i_sof -> load initial state, emit element-0 result, symbol counter = 1, go RUN.
REQ-020 IDLE: accepted symbol without i_sof -> drop symbol (no o_valid), pulse o_sync_err.
REQ-021 RUN: accepted symbol without i_sof -> emit, counter++; symbol FRAME_SYMS-1 (counter == FRAME_SYMS-1 at acceptance) emitted with o_last=1, go IDLE.
REQ-022 RUN: accepted symbol with i_sof -> resync: pulse o_sync_err, treat symbol as k=0 of new frame, counter = 1, stay RUN.
REQ-023 SHALL neither step LFSRs nor count when i_valid && !o_ready.

Reset
REQ-024 SHALL on i_reset: state IDLE, x/y to init values, counter 0, o_valid 0, o_last 0, o_data 2'b00, o_sync_err 0; o_ready=1 next cycle.
REQ-025 SHALL abandon a frame on reset mid-frame; discarded symbols never appear on output.

Configuration
REQ-026 SHALL with macro DERAND_FRAME_CNT_EN defined add output o_frame_cnt [15:0], reset 0, incremented when o_last symbol is accepted downstream, wrapping 16'hFFFF -> 0.
REQ-027 SHALL without DERAND_FRAME_CNT_EN omit o_frame_cnt port and counter entirely.

Structure
REQ-028 SHALL place X_INIT, Y_INIT constants and state enum type in package derand_pkg.
REQ-029 SHALL instantiate sub-module gold_seq_gen (i_clk, i_reset, i_load, i_step, o_seq[1:0]) holding x/y and combinational o_seq.

Verification
REQ-030 Reset, then frame of all-zero symbols with i_sof on first, i_ready=1 -> o_data 2'b00, 2'b01, 2'b01 for k=0,1,2.
REQ-031 FRAME_SYMS=16, output of matching transmitter fed in -> recovered payload bit-exact, o_last only on 16th output.
REQ-032 i_valid=1, i_sof=0 in IDLE -> no o_valid, o_sync_err high exactly one cycle, state stays IDLE.
REQ-033 i_sof at k=5 mid-frame -> o_sync_err pulse, that symbol XORed with 2'b00, o_last after 16 further symbols.
REQ-034 i_ready=0 for 3 cycles with o_valid high -> o_data held, o_ready=0, no symbol lost or duplicated after release.
REQ-035 i_reset at k=7 then new frame -> first output uses element 0; with DERAND_FRAME_CNT_EN, o_frame_cnt unchanged by aborted frame.
